// File: rtl/acc_ram_sweep_if.sv
// Request/response bundle between the control unit and the accumulator RAM.
// The control unit is the master. The RAM is the slave.
interface acc_ram_sweep_if #(
  parameter int unsigned A = 8,
  parameter int unsigned W = 16
) ();
  logic         enable;
  logic         read_en;
  logic         write_en;
  logic [A-1:0] addr;
  logic [W-1:0] datain;
  logic         zero_req;
  logic [W-1:0] dataout;
  logic         rvalid;
  logic         busy;
  logic         sweep_done;

  modport master (
    output enable, read_en, write_en, addr, datain, zero_req,
    input  dataout, rvalid, busy, sweep_done
  );

  modport slave (
    input  enable, read_en, write_en, addr, datain, zero_req,
    output dataout, rvalid, busy, sweep_done
  );
endinterface

// File: rtl/acc_ram_sweep.sv
// Single-port data/program RAM for the accumulator processor.
// Reads are write-first with a 1- or 2-cycle latency. A zeroing sweep runs one address per cycle.
module acc_ram_sweep #(
  parameter int unsigned A      = 8,
  parameter int unsigned W      = 16,
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            clear,
  acc_ram_sweep_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [A:0] LAST_ADDR = {1'b0, {A{1'b1}}};

  state_t       state, state_nx;
  logic [A:0]   sweep_addr;
  logic         done_q;
  logic         busy_c;
  logic         last_sweep;
  logic         idle_access;
  logic         rd_req;
  logic         wr_req;
  logic [W-1:0] rd_data;
  logic [W-1:0] dout_q;
  logic         rvalid_q;

  // The declaration initialiser gives all-zero contents at time 0. Reset never touches the array.
  logic [W-1:0] mem [2**A] = '{default: '0};

  always_comb begin
    state_nx    = state;
    busy_c      = 1'b0;
    last_sweep  = 1'b0;
    idle_access = 1'b0;
    case (state)
      IDLE: begin
        if (bus.zero_req) state_nx = SWEEP;
        else              idle_access = bus.enable;
      end
      SWEEP: begin
        busy_c = 1'b1;
        if (sweep_addr == LAST_ADDR) begin
          last_sweep = 1'b1;
          state_nx   = IDLE;
        end
      end
    endcase
  end

  assign rd_req  = idle_access && bus.read_en;
  assign wr_req  = idle_access && bus.write_en;
  assign rd_data = bus.write_en ? bus.datain : mem[bus.addr];

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      sweep_addr <= '0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_sweep;
      if (state == SWEEP) sweep_addr <= sweep_addr + (A+1)'(1);
      else                sweep_addr <= '0;
    end
  end

  // No write lands on the edge where clear is asserted, including an in-flight sweep write.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (state == SWEEP) mem[sweep_addr[A-1:0]] <= '0;
      else if (wr_req)    mem[bus.addr]          <= bus.datain;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (clear) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_req;
          if (rd_req) dout_q <= rd_data;
        end
      end
    end else begin : g_lat2
      logic [W-1:0] s1_data;
      logic         s1_valid;

      always_ff @(posedge clk) begin
        if (clear) begin
          s1_valid <= 1'b0;
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          s1_valid <= rd_req;
          rvalid_q <= s1_valid;
          if (rd_req)   s1_data <= rd_data;
          if (s1_valid) dout_q  <= s1_data;
        end
      end
    end
  endgenerate

  assign bus.dataout    = dout_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.busy       = busy_c;
  assign bus.sweep_done = done_q;

endmodule

// File: tb/tb_acc_ram_sweep.sv
// Bench for acc_ram_sweep with both read latencies driven in lockstep.
// A read scoreboard and a sweep-state model are checked on every cycle.
module tb_acc_ram_sweep;
  localparam int unsigned A = 8;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  acc_ram_sweep_if #(.A(A), .W(W)) bus1 ();
  acc_ram_sweep_if #(.A(A), .W(W)) bus2 ();

  acc_ram_sweep #(.A(A), .W(W), .RD_LAT(1)) dut1 (.clk(clk), .clear(clear), .bus(bus1));
  acc_ram_sweep #(.A(A), .W(W), .RD_LAT(2)) dut2 (.clk(clk), .clear(clear), .bus(bus2));

  typedef struct {
    logic [W-1:0] data;
    int           req;
  } exp_t;

  typedef struct {
    bit           en, rd, wr;
    logic [A-1:0] a;
    logic [W-1:0] d;
    bit           zr, clr;
    logic [W-1:0] exp;
  } vec_t;

  exp_t         q[$];
  int           p1 = 0, p2 = 0;
  logic [W-1:0] hold1 = '0, hold2 = '0;
  int           errors = 0, checks = 0, cyc = 0;
  bit           sweeping = 1'b0, exp_done = 1'b0;
  int           sidx = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input int lat, input string tag, input logic rv, input logic [W-1:0] dout,
                           input logic bsy, input logic dn, inout int p, inout logic [W-1:0] hold);
    logic         exp_rv;
    logic [W-1:0] exp_d;
    exp_rv = 1'b0;
    exp_d  = hold;
    if (p < q.size() && q[p].req + lat - 1 == cyc) begin
      exp_rv = 1'b1;
      exp_d  = q[p].data;
      p++;
    end
    chk({tag, " rvalid"}, rv, exp_rv);
    chk({tag, " dataout"}, dout, exp_d);
    chk({tag, " busy"}, bsy, sweeping);
    chk({tag, " sweep_done"}, dn, exp_done);
    hold = exp_d;
  endtask

  task automatic step(input bit en, input bit rd, input bit wr, input logic [A-1:0] a,
                      input logic [W-1:0] d, input bit zr, input bit clr, input logic [W-1:0] exp_rd);
    bus1.enable = en; bus1.read_en = rd; bus1.write_en = wr;
    bus1.addr = a; bus1.datain = d; bus1.zero_req = zr;
    bus2.enable = en; bus2.read_en = rd; bus2.write_en = wr;
    bus2.addr = a; bus2.datain = d; bus2.zero_req = zr;
    clear = clr;
    @(posedge clk);
    cyc++;
    exp_done = 1'b0;
    if (clr) begin
      sweeping = 1'b0;
      p1 = q.size(); p2 = q.size();
      hold1 = '0; hold2 = '0;
    end else if (!sweeping) begin
      if (zr) begin
        sweeping = 1'b1;
        sidx = 0;
      end else if (en && rd) begin
        q.push_back('{exp_rd, cyc});
      end
    end else begin
      if (sidx == 2**A - 1) begin
        sweeping = 1'b0;
        exp_done = 1'b1;
      end
      sidx++;
    end
    #1;
    check_dut(1, "lat1", bus1.rvalid, bus1.dataout, bus1.busy, bus1.sweep_done, p1, hold1);
    check_dut(2, "lat2", bus2.rvalid, bus2.dataout, bus2.busy, bus2.sweep_done, p2, hold2);
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
    step(1, 0, 1, a, d, 0, 0, '0);
  endtask

  task automatic rd(input logic [A-1:0] a, input logic [W-1:0] exp);
    step(1, 1, 0, a, '0, 0, 0, exp);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic fill(input logic [W-1:0] d);
    for (int i = 0; i < 2**A; i++) wr(i[A-1:0], d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   nbusy, ndone;

    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 1, 16'h0000});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 1, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd5, 16'hBEEF, 0, 0, 16'h0000});
    vecs.push_back('{1, 1, 0, 8'd5, 16'h0000, 0, 0, 16'hBEEF});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd0, 16'h000A, 0, 0, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd1, 16'h000B, 0, 0, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd2, 16'h000C, 0, 0, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd3, 16'h000D, 0, 0, 16'h0000});
    vecs.push_back('{1, 1, 0, 8'd0, 16'h0000, 0, 0, 16'h000A});
    vecs.push_back('{1, 1, 0, 8'd1, 16'h0000, 0, 0, 16'h000B});
    vecs.push_back('{1, 1, 0, 8'd2, 16'h0000, 0, 0, 16'h000C});
    vecs.push_back('{1, 1, 0, 8'd3, 16'h0000, 0, 0, 16'h000D});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{1, 1, 1, 8'd3, 16'h1234, 0, 0, 16'h1234});
    vecs.push_back('{1, 1, 0, 8'd3, 16'h0000, 0, 0, 16'h1234});
    vecs.push_back('{0, 0, 1, 8'd6, 16'h5555, 0, 0, 16'h0000});
    vecs.push_back('{0, 1, 0, 8'd6, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{1, 1, 0, 8'd6, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{1, 0, 1, 8'd5, 16'h0001, 0, 0, 16'h0000});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{1, 1, 0, 8'd5, 16'h0000, 0, 0, 16'h0001});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});
    vecs.push_back('{0, 0, 0, 8'd0, 16'h0000, 0, 0, 16'h0000});

    foreach (vecs[i])
      step(vecs[i].en, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].zr, vecs[i].clr, vecs[i].exp);

    // The sweep runs to completion after a read issued just before zero_req.
    fill(16'hA5A5);
    rd(8'd7, 16'hA5A5);
    step(1, 1, 0, 8'd8, '0, 1, 0, '0);
    nbusy = int'(bus1.busy);
    ndone = 0;
    for (int i = 0; i < 262; i++) begin
      if (i == 20)      step(1, 0, 1, 8'd9, 16'h7777, 0, 0, '0);
      else if (i == 21) step(1, 1, 0, 8'd9, '0, 0, 0, '0);
      else              idle();
      nbusy += int'(bus1.busy);
      ndone += int'(bus1.sweep_done);
    end
    chk("sweep busy cycles", W'(nbusy), W'(256));
    chk("sweep_done pulses", W'(ndone), W'(1));
    rd(8'd0, 16'h0000);
    rd(8'd255, 16'h0000);
    rd(8'd9, 16'h0000);
    rd(8'd128, 16'h0000);
    idle();
    idle();

    // Clear asserted partway through the sweep aborts it.
    fill(16'hA5A5);
    step(0, 0, 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < 9; i++) idle();
    step(0, 0, 0, '0, '0, 0, 1, '0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      ndone += int'(bus2.sweep_done);
    end
    chk("aborted sweep_done", W'(ndone), W'(0));
    rd(8'd3, 16'h0000);
    rd(8'd200, 16'hA5A5);
    rd(8'd255, 16'hA5A5);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
